// File: rtl/keypad_code_collector_pkg.sv
// Shared keypad/lock definitions: special key codes and the collector state encoding.
package keypad_code_collector_pkg;

   localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
   localparam logic [3:0] KEY_CLEAR     = 4'd10;
   localparam logic [3:0] KEY_ENTER     = 4'd11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      FULL  = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Keys 12..15 have no function on this keypad.
   function automatic logic is_key(input logic [3:0] key);
      return key <= KEY_ENTER;
   endfunction

   function automatic logic is_digit(input logic [3:0] key);
      return key <= KEY_MAX_DIGIT;
   endfunction

endpackage

// File: rtl/keypad_code_collector_key_press_detector.sv
// Converts the encoder's level valid into a single press event on the rising edge of valid.
module key_press_detector
   import keypad_code_collector_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       valid_i,
   input  logic [3:0] code_i,
   output logic       press_c_o,
   output logic [3:0] key_c_o
);

   logic valid_q;

   // Any valid, including unused codes, arms the edge detector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_i;
      end
   end

   assign press_c_o = valid_i & ~valid_q & is_key(code_i);
   assign key_c_o   = code_i;

endmodule

// File: rtl/keypad_code_collector.sv
// Assembles a NUM_DIGITS PIN from keypad press events; clear/enter keys and an idle timeout control entry.
module keypad_code_collector
   import keypad_code_collector_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [3:0]                         code,
   input  logic                               valid,
   output logic [4*NUM_DIGITS-1:0]            entered_code,
   output logic [$clog2(NUM_DIGITS+1)-1:0]    digit_count,
   output logic                               entry_done,
   output logic                               entry_error,
   output logic                               entry_cleared,
   output logic                               entry_timeout
);

   localparam int unsigned BW = 4 * NUM_DIGITS;
   localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

   logic          press_c;
   logic [3:0]    key_c;

   state_e        state_q, state_d;
   logic [BW-1:0] buffer_q, buffer_d;
   logic [CW-1:0] count_q, count_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic          cleared_q, cleared_d;
   logic          timeout_q, timeout_d;

   key_press_detector u_press (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (valid),
      .code_i    (code),
      .press_c_o (press_c),
      .key_c_o   (key_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         buffer_q  <= '0;
         count_q   <= '0;
         timer_q   <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         cleared_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         buffer_q  <= buffer_d;
         count_q   <= count_d;
         timer_q   <= timer_d;
         done_q    <= done_d;
         error_q   <= error_d;
         cleared_q <= cleared_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      buffer_d  = buffer_q;
      count_d   = count_q;
      timer_d   = timer_q;
      done_d    = 1'b0;
      error_d   = 1'b0;
      cleared_d = 1'b0;
      timeout_d = 1'b0;

      case (state_q)
         IDLE, ENTRY, FULL: begin
            // A press always wins over an expiring timer in the same cycle.
            if (press_c) begin
               timer_d = '0;
               if (is_digit(key_c)) begin
                  if (state_q != FULL) begin
                     buffer_d = (buffer_q << 4) | BW'(key_c);
                     count_d  = count_q + CW'(1);
                     state_d  = (count_q == CW'(NUM_DIGITS - 1)) ? FULL : ENTRY;
                  end
               end else if (key_c == KEY_CLEAR) begin
                  buffer_d  = '0;
                  count_d   = '0;
                  cleared_d = 1'b1;
                  state_d   = IDLE;
               end else if (state_q == FULL) begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  buffer_d = '0;
                  count_d  = '0;
                  error_d  = 1'b1;
                  state_d  = IDLE;
               end
            end else if (state_q == IDLE) begin
               timer_d = '0;
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               buffer_d  = '0;
               count_d   = '0;
               timer_d   = '0;
               cleared_d = 1'b1;
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         DONE: begin
            buffer_d = '0;
            count_d  = '0;
            timer_d  = '0;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign entered_code  = buffer_q;
   assign digit_count   = count_q;
   assign entry_done    = done_q;
   assign entry_error   = error_q;
   assign entry_cleared = cleared_q;
   assign entry_timeout = timeout_q;

endmodule
